// File: rtl/seg_display_driver.sv
// Four-digit multiplexed 7-segment driver: shows a 16-bit value in hex or
// decimal (double-dabble), with optional leading-zero blanking.
module seg_display_driver #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] result,
    input  logic        mode,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        busy
);

    localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        COMMIT
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [16:0] r_stored;
    logic [15:0] r_bcd;
    logic [15:0] r_bin;
    logic [3:0]  r_iter;
    logic [15:0] r_disp;
    logic        r_dash;
    logic [CW-1:0] r_scan_cnt;
    logic [1:0]  r_dig_idx;
    logic [7:0]  r_seg;
    logic [3:0]  r_an;

    logic [16:0] w_in;
    logic        w_diff;
    logic [15:0] w_adj;
    logic [31:0] w_shift;
    logic [15:0] w_upper;
    logic [3:0]  w_nib;
    logic        w_blank;
    logic [7:0]  w_seg_nxt;
    logic [3:0]  w_an_nxt;

    function automatic logic [6:0] f_hex7(input logic [3:0] n);
        case (n)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    always_comb begin
        w_in   = {mode, result};
        w_diff = (w_in != r_stored);
        for (int unsigned k = 0; k < 4; k++) begin
            w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3
                                                         : r_bcd[4*k +: 4];
        end
        w_shift = {w_adj, r_bin} << 1;
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != IDLE);
        case (r_state)
            IDLE:    if (w_diff) w_next = LOAD;
            LOAD:    w_next = SHIFT;
            SHIFT:   if (r_iter == 4'd15) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Hex mode still walks LOAD/SHIFT/COMMIT so update latency never depends on mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stored <= '0;
            r_bcd    <= '0;
            r_bin    <= '0;
            r_iter   <= '0;
            r_disp   <= '0;
            r_dash   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_diff) r_stored <= w_in;
                end
                LOAD: begin
                    r_bcd  <= '0;
                    r_bin  <= r_stored[15:0];
                    r_iter <= '0;
                end
                SHIFT: begin
                    r_bcd  <= w_shift[31:16];
                    r_bin  <= w_shift[15:0];
                    r_iter <= r_iter + 4'd1;
                end
                COMMIT: begin
                    if (!r_stored[16]) begin
                        r_disp <= r_stored[15:0];
                        r_dash <= 1'b0;
                    end else if (r_stored[15:0] > 16'd9999) begin
                        r_disp <= '0;
                        r_dash <= 1'b1;
                    end else begin
                        r_disp <= r_bcd;
                        r_dash <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        w_upper   = r_disp >> {r_dig_idx, 2'b00};
        w_nib     = w_upper[3:0];
        w_blank   = LZ_BLANK && !r_dash && (r_dig_idx != 2'd0) && (w_upper == 16'd0);
        w_an_nxt  = ~(4'b0001 << r_dig_idx);
        if (r_dash) begin
            w_seg_nxt = 8'hBF;
        end else if (w_blank) begin
            w_seg_nxt = 8'hFF;
        end else begin
            w_seg_nxt = {1'b1, f_hex7(w_nib)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_dig_idx  <= '0;
            r_seg      <= 8'hFF;
            r_an       <= 4'hF;
        end else begin
            if (r_scan_cnt == CW'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_dig_idx  <= r_dig_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench for seg_display_driver: expected digit patterns are queued
// at stimulus time and compared against the scanned seg/an after each update.
module tb_seg_display_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] result;
    logic        mode;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        busy;

    int checks;
    int errors;
    logic [16:0] model_stored;
    logic [31:0] exp_q[$];

    seg_display_driver #(
        .SCAN_DIV(4),
        .LZ_BLANK(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .result(result),
        .mode  (mode),
        .seg   (seg),
        .an    (an),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: digits from plain arithmetic, then leading-zero blanking.
    function automatic logic [31:0] model_segs(input logic m, input int unsigned v);
        logic [7:0]  tab[16];
        int unsigned d[4];
        int unsigned p;
        logic [31:0] r;
        bit          lead;
        tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        if (m && v > 9999) return {4{8'hBF}};
        p = 1;
        for (int k = 0; k < 4; k++) begin
            d[k] = m ? (v / p) % 10 : (v >> (4 * k)) & 15;
            p = p * 10;
        end
        r = '0;
        lead = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            if (d[k] != 0) lead = 1'b0;
            r[8*k +: 8] = (lead && k != 0) ? 8'hFF : tab[d[k]];
        end
        return r;
    endfunction

    task automatic issue(input logic m, input logic [15:0] v);
        @(negedge clk);
        mode   = m;
        result = v;
        if ({m, v} != model_stored) begin
            exp_q.push_back(model_segs(m, v));
            model_stored = {m, v};
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic scan_collect(output logic [31:0] got, output logic [3:0] seen);
        got  = '1;
        seen = '0;
        repeat (16) begin
            @(negedge clk);
            case (an)
                4'b1110: begin got[7:0]   = seg; seen[0] = 1'b1; end
                4'b1101: begin got[15:8]  = seg; seen[1] = 1'b1; end
                4'b1011: begin got[23:16] = seg; seen[2] = 1'b1; end
                4'b0111: begin got[31:24] = seg; seen[3] = 1'b1; end
                default: seen = seen;
            endcase
        end
    endtask

    // Monitor: a busy falling edge marks a display update; scan it and compare.
    initial begin
        int          bc;
        logic [31:0] got;
        logic [31:0] e;
        logic [3:0]  seen;
        bc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bc = 0;
            end else if (busy) begin
                bc++;
            end else if (bc != 0) begin
                chk("busy_len", bc, 18);
                bc = 0;
                e  = '1;
                if (exp_q.size() == 0) chk("unexpected_update", 1, 0);
                else e = exp_q.pop_front();
                got  = '1;
                seen = '0;
                repeat (16) begin
                    @(negedge clk);
                    if (!rst_n) bc = 0;
                    else if (busy) bc++;
                    case (an)
                        4'b1110: begin got[7:0]   = seg; seen[0] = 1'b1; end
                        4'b1101: begin got[15:8]  = seg; seen[1] = 1'b1; end
                        4'b1011: begin got[23:16] = seg; seen[2] = 1'b1; end
                        4'b0111: begin got[31:24] = seg; seen[3] = 1'b1; end
                        default: seen = seen;
                    endcase
                end
                chk("digits_seen", int'(seen), 15);
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("digit%0d", k), int'(got[8*k +: 8]), int'(e[8*k +: 8]));
                end
            end
        end
    end

    initial begin
        logic [31:0] got;
        logic [3:0]  seen;
        int          n;
        bit          went_high;

        checks = 0;
        errors = 0;
        model_stored = '0;
        rst_n  = 1'b0;
        mode   = 1'b0;
        result = 16'd0;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_an", int'(an), 4'hF);
        chk("rst_seg", int'(seg), 8'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_an", int'(an), 4'hE);
        chk("rel_seg", int'(seg), 8'hC0);
        scan_collect(got, seen);
        chk("zero_seen", int'(seen), 15);
        chk("zero_digits", int'(got), int'(32'hFFFFFFC0));
        chk("zero_busy", int'(busy), 0);

        issue(1'b1, 16'd1234);
        wait_idle();
        issue(1'b1, 16'd65535);
        wait_idle();
        issue(1'b0, 16'h0A08);
        wait_idle();

        // Change while converting: both values must reach the display in order.
        issue(1'b1, 16'd1234);
        repeat (7) @(posedge clk);
        chk("busy_mid", int'(busy), 1);
        issue(1'b1, 16'd5678);
        wait_idle();
        @(negedge clk);
        chk("restart", int'(busy), 1);
        wait_idle();

        // Reset in the middle of a conversion.
        repeat (20) @(negedge clk);
        mode   = 1'b1;
        result = 16'd4321;
        repeat (8) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_an", int'(an), 4'hF);
        chk("abort_seg", int'(seg), 8'hFF);
        exp_q.delete();
        model_stored = {1'b1, 16'd4321};
        exp_q.push_back(model_segs(1'b1, 32'd4321));
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_rel_an", int'(an), 4'hE);
        chk("abort_rel_seg", int'(seg), 8'hC0);
        n = 0;
        went_high = 1'b0;
        while (n < 64 && !(went_high && !an[0])) begin
            @(negedge clk);
            n++;
            if (an[0]) went_high = 1'b1;
        end
        chk("scan_period", n, 16);
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            logic        m;
            int unsigned v;
            int unsigned sel;
            m   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 2);
            v   = (sel == 0) ? $urandom_range(0, 15)
                : (sel == 1) ? $urandom_range(0, 9999)
                             : $urandom_range(0, 65535);
            issue(m, 16'(v));
            wait_idle();
        end

        repeat (24) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
